wt_dcache_mem_responder: RTL and testbench

// - Memory-side responder for the write-through (WT) data cache miss/store interface.
// - Accepts one cache request at a time: line refill, non-cacheable word load or write-through store.
// - Converts the request into single-word beats on an SRAM-style req/gnt/rvalid port.
// - Returns one ID-tagged response per request. Sits between the WT dcache and the memory/bus adapter.

---
 rtl/wt_dcache_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_wt_dcache_mem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_mem_responder.sv
// WT dcache memory responder: turns one cache request (refill, NC load or
// write-through store) into single-word SRAM-style beats and returns one
// ID-tagged response carrying the assembled line.

// One line-buffer lane: loads a memory word, clears when the response retires.
module wt_dcache_mem_lane #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_we,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // Lane storage; clear has priority so a retiring response never leaks data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_we)  r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module wt_dcache_mem_responder #(
  parameter int XLEN       = 32,
  parameter int LINE_WIDTH = 128,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic                  req_nc_i,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  input  logic [XLEN-1:0]       req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  input  logic [XLEN/8-1:0]     req_be_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [XLEN-1:0]       mem_addr_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  output logic [XLEN/8-1:0]     mem_be_o,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_store_o,
  output logic [ID_WIDTH-1:0]   rsp_id_o,
  output logic [LINE_WIDTH-1:0] rsp_data_o
);
  // Line must hold at least two words so the lane index below is non-empty.
  localparam int BEATS = LINE_WIDTH / XLEN;
  localparam int BOFF  = $clog2(XLEN / 8);
  localparam int LOFF  = $clog2(LINE_WIDTH / 8);
  localparam int CW    = $clog2(BEATS);
  localparam logic [XLEN-1:0] WORD_MASK = {XLEN{1'b1}} << BOFF;
  localparam logic [XLEN-1:0] LINE_MASK = {XLEN{1'b1}} << LOFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                  r_state, w_state_nxt;
  logic                    r_store, r_nc;
  logic [ID_WIDTH-1:0]     r_id;
  logic [XLEN-1:0]         r_base;
  logic [XLEN-1:0]         r_wdata;
  logic [XLEN/8-1:0]       r_be;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           r_lane;
  logic [BEATS-1:0][XLEN-1:0] w_line;

  logic w_accept, w_beat_done, w_refill, w_last, w_rsp_hs;

  assign w_accept    = req_valid_i && (r_state == S_IDLE);
  // A beat completes on rvalid in WAIT, or on rvalid coinciding with the grant.
  assign w_beat_done = ((r_state == S_ISSUE) && mem_gnt_i && mem_rvalid_i) ||
                       ((r_state == S_WAIT) && mem_rvalid_i);
  assign w_refill    = !r_store && !r_nc;
  assign w_last      = !w_refill || (r_cnt == CW'(BEATS - 1));
  assign w_rsp_hs    = (r_state == S_RESP) && rsp_ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state: one beat outstanding at most; refills loop ISSUE/WAIT per word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: if (mem_gnt_i) begin
                 if (mem_rvalid_i) w_state_nxt = w_last ? S_RESP : S_ISSUE;
                 else              w_state_nxt = S_WAIT;
               end
      S_WAIT:  if (mem_rvalid_i) w_state_nxt = w_last ? S_RESP : S_ISSUE;
      S_RESP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the request; loads always drive full byte enables on the memory side.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_store <= 1'b0;
      r_nc    <= 1'b0;
      r_id    <= '0;
      r_base  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_lane  <= '0;
    end else if (w_accept) begin
      r_store <= req_store_i;
      r_nc    <= req_nc_i;
      r_id    <= req_id_i;
      r_base  <= (!req_store_i && !req_nc_i) ? (req_addr_i & LINE_MASK)
                                             : (req_addr_i & WORD_MASK);
      r_wdata <= req_wdata_i;
      r_be    <= req_store_i ? req_be_i : {(XLEN/8){1'b1}};
      r_lane  <= req_addr_i[LOFF-1:BOFF];
    end
  end

  // Beat counter: advances per completed refill word, cleared on retire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     r_cnt <= '0;
    else if (w_accept || w_rsp_hs)   r_cnt <= '0;
    else if (w_beat_done && !w_last) r_cnt <= r_cnt + 1'b1;
  end

  // Line buffer: refill writes lane cnt, NC load writes its address lane.
  for (genvar i = 0; i < BEATS; i++) begin : g_lane
    wt_dcache_mem_lane #(.W(XLEN)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_we   (w_beat_done && !r_store &&
               (r_nc ? (r_lane == CW'(i)) : (r_cnt == CW'(i)))),
      .i_clr  (w_rsp_hs),
      .i_d    (mem_rdata_i),
      .o_q    (w_line[i])
    );
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign mem_req_o   = (r_state == S_ISSUE);
  assign mem_we_o    = r_store;
  assign mem_addr_o  = r_base + XLEN'({r_cnt, {BOFF{1'b0}}});
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_store_o = r_store;
  assign rsp_id_o    = r_id;
  assign rsp_data_o  = w_line;
endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Scoreboard bench: driver pushes expected beats/responses, a memory model
// checks beats and a response monitor pops and compares.
module tb_wt_dcache_mem_responder;
  localparam int XLEN = 32, LW = 128, IDW = 1;

  logic            clk_i = 1'b0, rst_ni = 1'b0;
  logic            req_valid_i, req_ready_o, req_store_i, req_nc_i;
  logic [IDW-1:0]  req_id_i;
  logic [31:0]     req_addr_i, req_wdata_i;
  logic [3:0]      req_be_i;
  logic            mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [31:0]     mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]      mem_be_o;
  logic            rsp_valid_o, rsp_ready_i, rsp_store_o;
  logic [IDW-1:0]  rsp_id_o;
  logic [LW-1:0]   rsp_data_o;

  wt_dcache_mem_responder #(.XLEN(XLEN), .LINE_WIDTH(LW), .ID_WIDTH(IDW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_nc_i(req_nc_i), .req_id_i(req_id_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_store_o(rsp_store_o),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic st; logic [IDW-1:0] id; logic [LW-1:0] data; } rsp_t;
  typedef struct packed { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be; } beat_t;

  rsp_t  exp_rsp[$];
  beat_t exp_beat[$];
  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, lat = 0, last_vcnt = 0, beats_seen = 0;
  int mode = 0, gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0, rdy_pct = 100, rdy_lo = 0;
  bit outstanding = 0;
  logic [LW-1:0] last_data;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents as a pure function of address (mode selects directed patterns).
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (mode)
      1:       return 32'hA0 + 32'(a[3:2]);
      2:       return 32'hDEADBEEF;
      default: return (a * 32'h9E37_79B9) ^ 32'h5A5A_3C3C;
    endcase
  endfunction

  // Memory model: random grant/rvalid delays, spurious rvalids when nothing is pending.
  initial begin
    bit in_req, pend;
    int gcnt, rcnt;
    logic [31:0] pa, pdata;
    beat_t b;
    in_req = 0; pend = 0; gcnt = 0; rcnt = 0; pa = '0; pdata = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = $urandom;
      if (!rst_ni) begin in_req = 0; pend = 0; continue; end
      if (pend) begin
        if (rcnt == 0) begin mem_rvalid_i = 1; mem_rdata_i = pdata; pend = 0; end
        else rcnt--;
      end else if (in_req || mem_req_o) begin
        if (!in_req) begin
          in_req = 1; beats_seen++; pa = mem_addr_o;
          chk("beat_expected", LW'(exp_beat.size() > 0), 1);
          if (exp_beat.size() > 0) begin
            b = exp_beat.pop_front();
            chk("beat_addr", mem_addr_o, b.addr);
            chk("beat_we", mem_we_o, b.we);
            chk("beat_be", mem_be_o, b.be);
            if (b.we) chk("beat_wdata", mem_wdata_o, b.wdata);
          end
          gcnt = $urandom_range(gnt_max, gnt_min);
        end else begin
          chk("req_hold", mem_req_o, 1);
          chk("req_hold_addr", mem_addr_o, pa);
        end
        if (gcnt == 0) begin
          mem_gnt_i = 1; in_req = 0; pdata = mem_val(pa);
          rcnt = $urandom_range(rv_max, rv_min);
          if (rcnt == 0) begin mem_rvalid_i = 1; mem_rdata_i = pdata; end
          else begin pend = 1; rcnt--; end
        end else begin
          gcnt--;
          if ($urandom_range(7, 0) == 0) mem_rvalid_i = 1;
        end
      end else if ($urandom_range(7, 0) == 0) mem_rvalid_i = 1;
    end
  end

  // Response monitor: stability while stalled, pop-and-compare on handshake.
  initial begin
    int vcnt;
    bit seen;
    rsp_t e, snap;
    vcnt = 0; seen = 0; snap = '0; rsp_ready_i = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rdy_lo > 0) rsp_ready_i = (vcnt >= rdy_lo);
      else            rsp_ready_i = ($urandom_range(99, 0) < rdy_pct);
      @(negedge clk_i);
      if (!rst_ni) begin seen = 0; vcnt = 0; continue; end
      if (outstanding) chk("ready_while_busy", req_ready_o, 0);
      if (rsp_valid_o) begin
        if (!seen) begin
          seen = 1; lat = cyc - acc_cyc;
          snap = '{st: rsp_store_o, id: rsp_id_o, data: rsp_data_o};
        end else begin
          chk("rsp_hold_store", rsp_store_o, snap.st);
          chk("rsp_hold_id", rsp_id_o, snap.id);
          chk("rsp_hold_data", rsp_data_o, snap.data);
        end
        vcnt++;
        if (rsp_ready_i) begin
          chk("rsp_expected", LW'(exp_rsp.size() > 0), 1);
          if (exp_rsp.size() > 0) begin
            e = exp_rsp.pop_front();
            chk("rsp_store", rsp_store_o, e.st);
            chk("rsp_id", rsp_id_o, e.id);
            chk("rsp_data", rsp_data_o, e.data);
          end
          last_data = rsp_data_o; last_vcnt = vcnt;
          seen = 0; vcnt = 0; outstanding = 0;
        end
      end
    end
  end

  // Issue one request and push its expected beats and response.
  task automatic send(input logic st, input logic nc, input logic [IDW-1:0] id,
                      input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    rsp_t r; beat_t b; logic [31:0] w; int n;
    @(posedge clk_i); #1;
    req_valid_i = 1; req_store_i = st; req_nc_i = nc; req_id_i = id;
    req_addr_i = a; req_wdata_i = wd; req_be_i = be;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (req_ready_o) break;
      if (++n > 500) begin chk("accept_timeout", req_ready_o, 1); req_valid_i = 0; return; end
    end
    acc_cyc = cyc;
    r = '{st: st, id: id, data: '0};
    if (st) begin
      b = '{addr: a & ~32'h3, we: 1'b1, wdata: wd, be: be}; exp_beat.push_back(b);
    end else if (nc) begin
      w = a & ~32'h3;
      b = '{addr: w, we: 1'b0, wdata: '0, be: 4'hF}; exp_beat.push_back(b);
      r.data = LW'(mem_val(w)) << (32 * a[3:2]);
    end else begin
      for (int i = 0; i < 4; i++) begin
        w = (a & ~32'hF) + 32'(4 * i);
        b = '{addr: w, we: 1'b0, wdata: '0, be: 4'hF}; exp_beat.push_back(b);
        r.data = r.data | (LW'(mem_val(w)) << (32 * i));
      end
    end
    exp_rsp.push_back(r);
    @(posedge clk_i); outstanding = 1;
    #1 req_valid_i = 0; req_addr_i = $urandom; req_wdata_i = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (outstanding || exp_rsp.size() > 0) begin
      @(negedge clk_i);
      if (++n > 1000) begin
        chk("idle_timeout", LW'(outstanding), 0);
        exp_rsp.delete(); exp_beat.delete(); outstanding = 0;
        break;
      end
    end
  endtask

  task automatic set_mem(input int gmin, input int gmax, input int rmin, input int rmax);
    gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax;
  endtask

  initial begin
    int n;
    req_valid_i = 0; req_store_i = 0; req_nc_i = 0; req_id_i = '0;
    req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
    #12;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    @(negedge clk_i); rst_ni = 1;

    // Store with immediate grant/rvalid: two-cycle latency, zero data.
    set_mem(0, 0, 0, 0); rdy_pct = 100;
    send(1, 0, 1'b1, 32'h1000_0006, 32'hCAFE_F00D, 4'hC);
    wait_idle();
    chk("store_latency", lat, 2);
    chk("store_data_zero", last_data, 0);

    // Directed refill pattern.
    mode = 1; set_mem(0, 1, 0, 1);
    send(0, 0, 1'b0, 32'h8000_0014, '0, '0);
    wait_idle();
    chk("refill_line", last_data, 128'h000000A3_000000A2_000000A1_000000A0);

    // Directed NC load lands in lane 2 only.
    mode = 2;
    send(0, 1, 1'b1, 32'h2000_0008, '0, '0);
    wait_idle();
    chk("nc_line", last_data, 128'h00000000_DEADBEEF_00000000_00000000);

    // Slow memory: grant after 3 cycles, rvalid 2 after grant.
    mode = 0; set_mem(3, 3, 2, 2);
    send(0, 0, 1'b1, 32'h0000_0040, '0, '0);
    send(1, 0, 1'b0, 32'h0000_0103, 32'h1234_5678, 4'h3);
    wait_idle();

    // Response back-pressure for 4 cycles; a queued request must wait.
    set_mem(0, 0, 0, 0); rdy_lo = 4;
    send(0, 1, 1'b0, 32'h3000_000C, '0, '0);
    send(1, 0, 1'b1, 32'h3000_0010, 32'hA5A5_5A5A, 4'hF);
    wait_idle();
    chk("rsp_stall_cycles", last_vcnt, 5);
    rdy_lo = 0;

    // Asynchronous reset during the third refill beat.
    set_mem(2, 2, 3, 3); beats_seen = 0;
    send(0, 0, 1'b0, 32'h4000_0020, '0, '0);
    n = 0;
    while (beats_seen < 3 && n < 300) begin @(negedge clk_i); n++; end
    chk("reset_reached_beat2", beats_seen, 3);
    #2 rst_ni = 0; #1;
    chk("arst_ready", req_ready_o, 1);
    chk("arst_mem_req", mem_req_o, 0);
    chk("arst_mem_addr", mem_addr_o, 0);
    chk("arst_rsp_valid", rsp_valid_o, 0);
    chk("arst_rsp_data", rsp_data_o, 0);
    exp_rsp.delete(); exp_beat.delete(); outstanding = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1;
    set_mem(0, 1, 0, 1);
    send(0, 0, 1'b1, 32'h4000_0024, '0, '0);
    wait_idle();

    // Randomized mix with random memory delays and response back-pressure.
    set_mem(0, 3, 0, 3); rdy_pct = 60;
    repeat (40) begin
      logic [31:0] a;
      a = ($urandom_range(4, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      send($urandom_range(2, 0) == 0, $urandom_range(1, 0) == 1, IDW'($urandom_range(1, 0)),
           a, $urandom, 4'($urandom_range(15, 1)));
    end
    wait_idle();
    chk("beat_queue_drained", exp_beat.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
